// File: rtl/kairos_io_pkg.sv
// Shared definitions for the Kairos IO stream bridge: ratio/level derivation,
// parameter sanity functions and the unpacker state encoding.
package kairos_io_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } unpack_state_e;

    function automatic int calc_ratio(input int data_width, input int io_width);
        return data_width / io_width;
    endfunction

    function automatic int calc_lvl_w(input int depth);
        return $clog2(depth) + 32'sd1;
    endfunction

    function automatic bit width_ok(input int data_width, input int io_width);
        return (io_width > 32'sd0) && (data_width >= io_width) &&
               ((data_width % io_width) == 32'sd0);
    endfunction

    function automatic bit depth_ok(input int depth);
        return (depth >= 32'sd2) && ((depth & (depth - 32'sd1)) == 32'sd0);
    endfunction

    // Bit offset of beat slot idx inside a core word.
    function automatic int slot_base(input int idx, input int ratio, input int io_width,
                                     input bit msb_first);
        return msb_first ? (ratio - 32'sd1 - idx) * io_width : idx * io_width;
    endfunction

endpackage

// File: rtl/kairos_sync_fifo.sv
// Single-clock word FIFO with level output; pointers wrap modulo DEPTH (power of two).
module kairos_sync_fifo
    import kairos_io_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = calc_lvl_w(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   level_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Status flags and qualified handshakes.
    always_comb begin
        full      = (level_r == LVL_W'(DEPTH));
        empty     = (level_r == '0);
        push_ok_s = push && !full;
        pop_ok_s  = pop && !empty;
        pop_data  = mem_r[rd_ptr_r];
        level     = level_r;
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_r <= level_r + LVL_W'(1'b1);
                2'b01:   level_r <= level_r - LVL_W'(1'b1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/kairos_io_stream_bridge.sv
// Packs IO-pad beats into core words via an input FIFO and unpacks core result
// words back into pad beats. Define KAIROS_IO_MSB_FIRST_EN for MSB-first beat order.
module kairos_io_stream_bridge
    import kairos_io_pkg::*;
#(
    parameter int IO_WIDTH   = 16,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                    io_clk,
    input  logic                    resetb,
    input  logic [IO_WIDTH-1:0]     io_in_data,
    input  logic                    io_in_vld,
    output logic                    io_in_rdy,
    output logic [DATA_WIDTH-1:0]   core_in_data,
    output logic                    core_in_vld,
    input  logic                    core_in_rdy,
    input  logic [DATA_WIDTH-1:0]   core_out_data,
    input  logic                    core_out_vld,
    output logic                    core_out_rdy,
    output logic [IO_WIDTH-1:0]     io_out_data,
    output logic                    io_out_vld,
    input  logic                    io_out_rdy,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic                    in_overrun
);
    localparam int RATIO = calc_ratio(DATA_WIDTH, IO_WIDTH);
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);
`ifdef KAIROS_IO_MSB_FIRST_EN
    localparam bit MSB_FIRST = 1'b1;
`else
    localparam bit MSB_FIRST = 1'b0;
`endif

    if (!width_ok(DATA_WIDTH, IO_WIDTH)) begin : g_bad_width
        $error("kairos_io_stream_bridge: DATA_WIDTH must be a multiple of IO_WIDTH");
    end
    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("kairos_io_stream_bridge: DEPTH must be a power of two >= 2");
    end

    logic [IDX_W-1:0]      beat_idx_r;
    logic [DATA_WIDTH-1:0] pack_r;
    logic [DATA_WIDTH-1:0] pack_nxt_s;
    logic                  in_overrun_r;
    logic                  last_beat_s;
    logic                  accept_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;

    // Packer handshake; io_in_rdy deliberately ignores a same-cycle pop.
    always_comb begin
        last_beat_s = (beat_idx_r == LAST_IDX);
        io_in_rdy   = !(last_beat_s && fifo_full_s);
        accept_s    = io_in_vld && io_in_rdy;
        push_s      = accept_s && last_beat_s;
        pop_s       = core_in_vld && core_in_rdy;
        pack_nxt_s  = pack_r;
        pack_nxt_s[slot_base(int'(beat_idx_r), RATIO, IO_WIDTH, MSB_FIRST) +: IO_WIDTH] = io_in_data;
    end

    // Pack register, beat index and sticky overrun flag.
    always_ff @(posedge io_clk or negedge resetb) begin
        if (!resetb) begin
            beat_idx_r   <= '0;
            pack_r       <= '0;
            in_overrun_r <= 1'b0;
        end else begin
            if (accept_s) begin
                beat_idx_r <= last_beat_s ? '0 : beat_idx_r + IDX_W'(1'b1);
                pack_r     <= last_beat_s ? '0 : pack_nxt_s;
            end
            if (io_in_vld && !io_in_rdy) begin
                in_overrun_r <= 1'b1;
            end
        end
    end

    assign in_overrun  = in_overrun_r;
    assign core_in_vld = !fifo_empty_s;

    kairos_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_in_fifo (
        .clk       (io_clk),
        .rst_n     (resetb),
        .push      (push_s),
        .push_data (pack_nxt_s),
        .pop       (pop_s),
        .pop_data  (core_in_data),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .level     (fifo_level)
    );

    unpack_state_e         state_r;
    unpack_state_e         state_nxt_s;
    logic [IDX_W-1:0]      out_idx_r;
    logic [IDX_W-1:0]      out_idx_nxt_s;
    logic [DATA_WIDTH-1:0] word_r;
    logic [DATA_WIDTH-1:0] word_nxt_s;
    logic [IO_WIDTH-1:0]   out_data_r;
    logic [IO_WIDTH-1:0]   out_data_nxt_s;
    logic                  out_vld_r;
    logic                  out_vld_nxt_s;
    logic                  out_last_s;
    logic                  load_s;

    // Unpacker next state; a word can load on the last beat for gapless output.
    always_comb begin
        out_last_s     = (out_idx_r == LAST_IDX);
        core_out_rdy   = (state_r == ST_IDLE) || (out_last_s && io_out_rdy);
        load_s         = core_out_vld && core_out_rdy;
        state_nxt_s    = state_r;
        out_idx_nxt_s  = out_idx_r;
        word_nxt_s     = word_r;
        out_data_nxt_s = out_data_r;
        out_vld_nxt_s  = out_vld_r;
        if (load_s) begin
            state_nxt_s    = ST_SEND;
            out_idx_nxt_s  = '0;
            word_nxt_s     = core_out_data;
            out_data_nxt_s = core_out_data[slot_base(32'sd0, RATIO, IO_WIDTH, MSB_FIRST) +: IO_WIDTH];
            out_vld_nxt_s  = 1'b1;
        end else begin
            case (state_r)
                ST_SEND: begin
                    if (io_out_rdy && out_last_s) begin
                        state_nxt_s   = ST_IDLE;
                        out_vld_nxt_s = 1'b0;
                    end else if (io_out_rdy) begin
                        out_idx_nxt_s  = out_idx_r + IDX_W'(1'b1);
                        out_data_nxt_s = word_r[slot_base(int'(out_idx_r) + 32'sd1, RATIO,
                                                          IO_WIDTH, MSB_FIRST) +: IO_WIDTH];
                    end else begin
                        out_vld_nxt_s = 1'b1;
                    end
                end
                ST_IDLE: begin
                    out_vld_nxt_s = 1'b0;
                end
                default: begin
                    state_nxt_s   = ST_IDLE;
                    out_vld_nxt_s = 1'b0;
                end
            endcase
        end
    end

    // Unpacker registers; outputs to the pads come straight from flops.
    always_ff @(posedge io_clk or negedge resetb) begin
        if (!resetb) begin
            state_r    <= ST_IDLE;
            out_idx_r  <= '0;
            word_r     <= '0;
            out_data_r <= '0;
            out_vld_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            out_idx_r  <= out_idx_nxt_s;
            word_r     <= word_nxt_s;
            out_data_r <= out_data_nxt_s;
            out_vld_r  <= out_vld_nxt_s;
        end
    end

    assign io_out_data = out_data_r;
    assign io_out_vld  = out_vld_r;

endmodule

// File: tb/tb_kairos_io_stream_bridge.sv
// Directed scoreboard bench for kairos_io_stream_bridge (16-bit beats, 32-bit words, depth 4).
module tb_kairos_io_stream_bridge;

    logic        io_clk = 1'b0;
    logic        resetb;
    logic [15:0] io_in_data;
    logic        io_in_vld;
    logic        io_in_rdy;
    logic [31:0] core_in_data;
    logic        core_in_vld;
    logic        core_in_rdy;
    logic [31:0] core_out_data;
    logic        core_out_vld;
    logic        core_out_rdy;
    logic [15:0] io_out_data;
    logic        io_out_vld;
    logic        io_out_rdy;
    logic [2:0]  fifo_level;
    logic        in_overrun;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_in_q[$];
    logic [15:0] exp_out_q[$];

    always #5 io_clk = ~io_clk;

    kairos_io_stream_bridge #(
        .IO_WIDTH   (16),
        .DATA_WIDTH (32),
        .DEPTH      (4)
    ) dut (
        .io_clk        (io_clk),
        .resetb        (resetb),
        .io_in_data    (io_in_data),
        .io_in_vld     (io_in_vld),
        .io_in_rdy     (io_in_rdy),
        .core_in_data  (core_in_data),
        .core_in_vld   (core_in_vld),
        .core_in_rdy   (core_in_rdy),
        .core_out_data (core_out_data),
        .core_out_vld  (core_out_vld),
        .core_out_rdy  (core_out_rdy),
        .io_out_data   (io_out_data),
        .io_out_vld    (io_out_vld),
        .io_out_rdy    (io_out_rdy),
        .fifo_level    (fifo_level),
        .in_overrun    (in_overrun)
    );

    function automatic logic [31:0] pack2(input logic [15:0] first, input logic [15:0] second);
`ifdef KAIROS_IO_MSB_FIRST_EN
        return {first, second};
`else
        return {second, first};
`endif
    endfunction

    function automatic logic [15:0] beat_of(input logic [31:0] word, input int k);
`ifdef KAIROS_IO_MSB_FIRST_EN
        return (k == 0) ? word[31:16] : word[15:0];
`else
        return (k == 0) ? word[15:0] : word[31:16];
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Handshake sampling on the falling edge: pop expectations, record accepted words.
    task automatic sample();
        if (core_in_vld === 1'b1 && core_in_rdy === 1'b1) begin
            if (exp_in_q.size() == 0) chk("in_word_unexpected", 32'(exp_in_q.size()), 32'd1);
            else chk("in_word", core_in_data, exp_in_q.pop_front());
        end
        if (io_out_vld === 1'b1 && io_out_rdy === 1'b1) begin
            if (exp_out_q.size() == 0) chk("out_beat_unexpected", 32'(exp_out_q.size()), 32'd1);
            else chk("out_beat", 32'(io_out_data), 32'(exp_out_q.pop_front()));
        end
        if (core_out_vld === 1'b1 && core_out_rdy === 1'b1) begin
            exp_out_q.push_back(beat_of(core_out_data, 0));
            exp_out_q.push_back(beat_of(core_out_data, 1));
        end
    endtask

    task automatic tick();
        @(negedge io_clk);
        sample();
        @(posedge io_clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_core_in_vld"}, 32'(core_in_vld), 32'd0);
        chk({tag, "_core_out_rdy"}, 32'(core_out_rdy), 32'd1);
        chk({tag, "_io_out_vld"}, 32'(io_out_vld), 32'd0);
        chk({tag, "_fifo_level"}, 32'(fifo_level), 32'd0);
        chk({tag, "_in_overrun"}, 32'(in_overrun), 32'd0);
        chk({tag, "_core_in_data"}, core_in_data, 32'd0);
        chk({tag, "_io_out_data"}, 32'(io_out_data), 32'd0);
    endtask

    initial begin
        resetb        = 1'b0;
        io_in_data    = 16'h0000;
        io_in_vld     = 1'b0;
        core_in_rdy   = 1'b0;
        core_out_data = 32'h0000_0000;
        core_out_vld  = 1'b0;
        io_out_rdy    = 1'b0;
        repeat (3) tick();
        resetb = 1'b1;
        #1;
        chk("rst_io_in_rdy", 32'(io_in_rdy), 32'd1);
        chk_reset_outputs("rst");

        // Pack two beats, core ready
        core_in_rdy = 1'b1;
        io_in_vld   = 1'b1;
        io_in_data  = 16'h1111;
        tick();
        io_in_data  = 16'h2222;
        exp_in_q.push_back(pack2(16'h1111, 16'h2222));
        tick();
        io_in_vld = 1'b0;
        chk("pack_vld", 32'(core_in_vld), 32'd1);
        chk("pack_data", core_in_data, pack2(16'h1111, 16'h2222));
        tick();
        chk("pack_vld_one_cycle", 32'(core_in_vld), 32'd0);

        // Fill the FIFO, then overrun
        core_in_rdy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            io_in_vld  = 1'b1;
            io_in_data = 16'h0A00 + 16'(i);
            if (i % 2 == 1) exp_in_q.push_back(pack2(16'h0A00 + 16'(i - 1), 16'h0A00 + 16'(i)));
            tick();
        end
        io_in_vld = 1'b0;
        #1;
        chk("fill_level", 32'(fifo_level), 32'd4);
        chk("fill_rdy_idx0", 32'(io_in_rdy), 32'd1);
        io_in_vld  = 1'b1;
        io_in_data = 16'h0A08;
        tick();
        io_in_vld = 1'b0;
        #1;
        chk("fill_rdy_blocked", 32'(io_in_rdy), 32'd0);
        io_in_vld  = 1'b1;
        io_in_data = 16'hDEAD;
        tick();
        io_in_vld = 1'b0;
        chk("overrun_set", 32'(in_overrun), 32'd1);
        chk("overrun_level", 32'(fifo_level), 32'd4);
        core_in_rdy = 1'b1;
        repeat (5) tick();
        chk("drain_level", 32'(fifo_level), 32'd0);
        io_in_vld  = 1'b1;
        io_in_data = 16'h0A09;
        exp_in_q.push_back(pack2(16'h0A08, 16'h0A09));
        tick();
        io_in_vld = 1'b0;
        tick();
        chk("overrun_sticky", 32'(in_overrun), 32'd1);
        chk("fill_inq_empty", 32'(exp_in_q.size()), 32'd0);

        // Simultaneous push and pop at level 2
        core_in_rdy = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            io_in_vld  = 1'b1;
            io_in_data = 16'h5000 + 16'(i);
            if (i % 2 == 0) exp_in_q.push_back(pack2(16'h5000 + 16'(i - 1), 16'h5000 + 16'(i)));
            tick();
        end
        chk("pp_level_pre", 32'(fifo_level), 32'd2);
        io_in_data  = 16'h5006;
        core_in_rdy = 1'b1;
        exp_in_q.push_back(pack2(16'h5005, 16'h5006));
        tick();
        io_in_vld   = 1'b0;
        core_in_rdy = 1'b0;
        #1;
        chk("pp_level_post", 32'(fifo_level), 32'd2);
        core_in_rdy = 1'b1;
        repeat (3) tick();
        chk("pp_level_drained", 32'(fifo_level), 32'd0);
        chk("pp_inq_empty", 32'(exp_in_q.size()), 32'd0);

        // Unpack with backpressure
        io_out_rdy    = 1'b1;
        core_out_vld  = 1'b1;
        core_out_data = 32'hAAAA_BBBB;
        #1;
        chk("unp_rdy_idle", 32'(core_out_rdy), 32'd1);
        tick();
        core_out_vld = 1'b0;
        io_out_rdy   = 1'b0;
        chk("unp_first_vld", 32'(io_out_vld), 32'd1);
        chk("unp_first_data", 32'(io_out_data), 32'(beat_of(32'hAAAA_BBBB, 0)));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("unp_hold_data", 32'(io_out_data), 32'(beat_of(32'hAAAA_BBBB, 0)));
            chk("unp_hold_vld", 32'(io_out_vld), 32'd1);
        end
        io_out_rdy = 1'b1;
        #1;
        chk("unp_rdy_mid", 32'(core_out_rdy), 32'd0);
        tick();
        chk("unp_second_data", 32'(io_out_data), 32'(beat_of(32'hAAAA_BBBB, 1)));
        chk("unp_rdy_last", 32'(core_out_rdy), 32'd1);
        tick();
        chk("unp_idle_vld", 32'(io_out_vld), 32'd0);

        // Back-to-back words with core_out_vld held
        core_out_vld  = 1'b1;
        core_out_data = 32'h1234_5678;
        tick();
        core_out_data = 32'h9ABC_DEF0;
        chk("b2b_vld0", 32'(io_out_vld), 32'd1);
        chk("b2b_rdy0", 32'(core_out_rdy), 32'd0);
        tick();
        chk("b2b_vld1", 32'(io_out_vld), 32'd1);
        chk("b2b_rdy1", 32'(core_out_rdy), 32'd1);
        tick();
        core_out_vld = 1'b0;
        chk("b2b_vld2", 32'(io_out_vld), 32'd1);
        chk("b2b_rdy2", 32'(core_out_rdy), 32'd0);
        chk("b2b_data2", 32'(io_out_data), 32'(beat_of(32'h9ABC_DEF0, 0)));
        tick();
        chk("b2b_vld3", 32'(io_out_vld), 32'd1);
        chk("b2b_rdy3", 32'(core_out_rdy), 32'd1);
        tick();
        chk("b2b_idle", 32'(io_out_vld), 32'd0);
        chk("b2b_outq_empty", 32'(exp_out_q.size()), 32'd0);

        // Reset in the middle of packing, FIFO content and an output word
        core_in_rdy = 1'b0;
        io_in_vld   = 1'b1;
        io_in_data  = 16'h6001;
        tick();
        io_in_data  = 16'h6002;
        exp_in_q.push_back(pack2(16'h6001, 16'h6002));
        tick();
        io_in_data    = 16'h7777;
        core_out_vld  = 1'b1;
        core_out_data = 32'h5555_6666;
        tick();
        io_in_vld    = 1'b0;
        core_out_vld = 1'b0;
        tick();
        chk("mid_level", 32'(fifo_level), 32'd1);
        chk("mid_out_vld", 32'(io_out_vld), 32'd1);
        resetb = 1'b0;
        #1;
        exp_in_q.delete();
        exp_out_q.delete();
        chk_reset_outputs("mrst");
        tick();
        tick();
        resetb = 1'b1;
        #1;
        chk("mrst_io_in_rdy", 32'(io_in_rdy), 32'd1);
        core_in_rdy = 1'b1;
        io_in_vld   = 1'b1;
        io_in_data  = 16'h3333;
        tick();
        io_in_data  = 16'h4444;
        exp_in_q.push_back(pack2(16'h3333, 16'h4444));
        tick();
        io_in_vld = 1'b0;
        chk("post_rst_vld", 32'(core_in_vld), 32'd1);
        chk("post_rst_data", core_in_data, pack2(16'h3333, 16'h4444));
        chk("post_rst_overrun", 32'(in_overrun), 32'd0);
        tick();
        chk("final_inq_empty", 32'(exp_in_q.size()), 32'd0);
        chk("final_outq_empty", 32'(exp_out_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
